net_tx_arb: RTL
===============

// Module: net_tx_arb
// PURPOSE
//  Shares the single 125 MHz GMII transmit path of the net block between two frame sources.
//  Grants one source at a time, round-robin on ties.
//  Wraps the granted frame in 7x 0x55 preamble + 0xD5 SFD and streams its bytes.
//  Enforces inter-frame gap, underrun abort and max-length truncation.
//  Sits between the frame generators and the RGMII DDR output stage (txd/txctl/txclk).
// PARAMETERS
//  IFG_LEN   12    idle byte times after every frame (incl. aborted/truncated), >=1
//  MAX_LEN   1518  max payload bytes per frame (after SFD, FCS supplied by source)
//  CNT_W     16    width of error counters (saturating)
// PORTS
//  clk125        in   1      125 MHz byte clock; all logic on rising edge
//  rst_n         in   1      synchronous reset, active-low
//  req           in   2      req[i]: source i has a frame ready; level, held until its gnt
//  gnt           out  2      one-cycle pulse, one-hot: source i's frame starts
//  s0_data/s1_data   in  8   payload byte from source i
//  s0_valid/s1_valid in  1   byte valid
//  s0_last/s1_last   in  1   byte is last of frame
//  s0_ready/s1_ready out 1   byte accepted when valid&&ready
//  gmii_txd      out  8      byte to RGMII stage
//  gmii_tx_en    out  1      frame in progress
//  gmii_tx_er    out  1      error byte (abort marker)
//  busy          out  1      state != IDLE
//  underrun_cnt  out  CNT_W  frames aborted by source underrun
//  trunc_cnt     out  CNT_W  frames truncated at MAX_LEN
// BEHAVIOUR
//  Reset: state IDLE, gnt=0, s*_ready=0, gmii_txd=0, tx_en=0, tx_er=0, busy=0, counters=0.
//  Reset: RR pointer set so source 0 wins the first tie. Reset mid-frame drops the frame silently.
//  All outputs are registered. A byte accepted in cycle t appears on gmii_txd in t+1.
//  IDLE: if any req at t: gnt pulses at t+1 and state=PRE. Tie: grant != last granted.
//  PRE: 7 cycles txd=0x55 tx_en=1, then SFD: 1 cycle txd=0xD5; first 0x55 on bus at t+1.
//  PAYLOAD: ready=1 for the selected source only (combinational from state+sel). Each accepted byte goes to txd, tx_en=1.
//   - Byte counter increments per accepted byte.
//   - Accepted byte with last: final byte out next cycle, then IFG.
//   - Underrun: valid=0 in PAYLOAD. Next cycle txd=0x00 tx_en=1 tx_er=1 for one byte. Then IFG; underrun_cnt++.
//   - Truncation: count==MAX_LEN and next byte valid without it being the end. Emit one tx_er byte (txd=0x00) instead of it.
//     Then DRAIN; trunc_cnt++.
//  DRAIN: tx_en=0. Selected ready=1, bytes discarded until accepted last, then IFG. valid gaps ignored.
//  IFG: tx_en=0 for IFG_LEN cycles, then IDLE. Requests arriving during IFG wait; grant on first IDLE cycle.
//  Unselected source ready=0 always. req deassertion while granted is ignored.
//  Counters saturate at all-ones. tx_er=1 only with tx_en=1.
// STRUCTURE
//  net_pkg: state enum {IDLE,PRE,SFD,PAYLOAD,DRAIN,IFG}, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, PRE_LEN=7.
//  Sub-module rr_arb2: 2-way round-robin arbiter (req, advance, gnt one-hot, last pointer).
//  Top: FSM, 11-bit byte counter, IFG down-counter, source mux, output regs.
// TESTING
//  1 src0 frame AA BB CC DD(last), req at t -> gnt[0]@t+1; 7x55,D5,AA,BB,CC,DD contiguous with tx_en; then 12 cycles tx_en=0.
//  2 both req from reset -> src0 frame, IFG, then src1; repeat both-req -> src0 again (alternation holds).
//  3 src1 drops valid after 2 bytes -> 2 bytes, then one byte tx_er=1 txd=00, tx_en low, underrun_cnt=1, IFG honoured.
//  4 MAX_LEN=8, 10-byte frame -> 8 bytes out, 9th tx_er; bytes 9-10 drained with ready=1; trunc_cnt=1.
//  5 rst_n low mid-payload -> next cycle tx_en=0 gnt=0 ready=0 busy=0, counters 0; new req granted normally.
//  6 req asserted at IFG cycle 5 -> no gnt until IFG ends; gnt on first IDLE cycle, preamble next.

Source files
------------

// File: rtl/net_pkg.sv
// net_pkg: state encoding and framing constants shared by the net transmit path.
package net_pkg;
  typedef enum logic [2:0] {IDLE, PRE, SFD, PAYLOAD, DRAIN, IFG} state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [2:0] PRE_LEN = 3'd7;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; a tie goes to the source not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic last;
  always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk) begin
    if (!rst_n) last <= 1'b1;
    else if (advance) last <= gnt[1];
  end
endmodule

// File: rtl/net_tx_arb.sv
// net_tx_arb: shares one GMII transmit path between two frame sources, adding preamble/SFD,
// inter-frame gap, underrun abort and max-length truncation.
module net_tx_arb
  import net_pkg::*;
#(
  parameter int IFG_LEN = 12,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk125,
  input  logic             rst_n,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  input  logic [7:0]       s0_data,
  input  logic             s0_valid,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic [7:0]       s1_data,
  input  logic             s1_valid,
  input  logic             s1_last,
  output logic             s1_ready,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic             busy,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] trunc_cnt
);
  localparam int IW = $clog2(IFG_LEN + 1);
  localparam logic [IW-1:0] IFG_LD = IW'(IFG_LEN - 1);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  state_t state;
  logic sel;
  logic [10:0] cnt;
  logic [2:0] pre_cnt;
  logic [IW-1:0] ifg_cnt;
  logic [1:0] arb_gnt;
  logic [7:0] data;
  logic valid, last, take;
  assign data = sel ? s1_data : s0_data;
  assign valid = sel ? s1_valid : s0_valid;
  assign last = sel ? s1_last : s0_last;
  assign take = (state == PAYLOAD) || (state == DRAIN);
  assign s0_ready = take && !sel;
  assign s1_ready = take && sel;
  assign busy = state != IDLE;
  rr_arb2 u_arb (
    .clk(clk125),
    .rst_n(rst_n),
    .req(req),
    .advance(state == IDLE && |req),
    .gnt(arb_gnt)
  );
  always_ff @(posedge clk125) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= 1'b0;
      cnt <= '0;
      pre_cnt <= '0;
      ifg_cnt <= '0;
      gnt <= '0;
      gmii_txd <= '0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      underrun_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      gnt <= '0;
      gmii_txd <= '0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          gnt <= arb_gnt;
          sel <= arb_gnt[1];
          pre_cnt <= '0;
          cnt <= '0;
          state <= PRE;
        end
        PRE: begin
          gmii_txd <= PREAMBLE_BYTE;
          gmii_tx_en <= 1'b1;
          pre_cnt <= pre_cnt + 3'd1;
          if (pre_cnt == PRE_LEN - 3'd1) state <= SFD;
        end
        SFD: begin
          gmii_txd <= SFD_BYTE;
          gmii_tx_en <= 1'b1;
          state <= PAYLOAD;
        end
        PAYLOAD: begin
          gmii_tx_en <= 1'b1;
          if (!valid) begin
            gmii_tx_er <= 1'b1;
            underrun_cnt <= underrun_cnt + {{(CNT_W-1){1'b0}}, ~&underrun_cnt};
            ifg_cnt <= IFG_LD;
            state <= IFG;
          end else if (cnt == MAX_L && !last) begin
            // the over-length byte is consumed and replaced by the abort marker
            gmii_tx_er <= 1'b1;
            trunc_cnt <= trunc_cnt + {{(CNT_W-1){1'b0}}, ~&trunc_cnt};
            state <= DRAIN;
          end else begin
            gmii_txd <= data;
            cnt <= cnt + 11'd1;
            if (last) begin
              ifg_cnt <= IFG_LD;
              state <= IFG;
            end
          end
        end
        DRAIN: if (valid && last) begin
          ifg_cnt <= IFG_LD;
          state <= IFG;
        end
        IFG: if (ifg_cnt == '0) state <= IDLE; else ifg_cnt <= ifg_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
